// File: rtl/stomp_arb_pkg.sv
// Shared phase encoding and default frame constants for the match sequencer / hit arbiter.
package stomp_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    ACTIVE    = 3'd2,
    RESPAWN   = 3'd3,
    HALT      = 3'd4
  } arb_phase_t;

  localparam int unsigned DEF_COUNTDOWN_FRAMES = 180;
  localparam int unsigned DEF_RESPAWN_FRAMES   = 60;
  localparam int unsigned DEF_INVULN_FRAMES    = 90;
  localparam int unsigned DEF_CNT_W            = 8;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over the decrement.
module frame_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count   = cnt_q;
  assign is_one  = (cnt_q == CNT_W'(1));
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/stomp_arbiter.sv
// Match sequencer and stomp-hit arbiter: countdown, start pulse, edge-detected hits with
// tie fairness, respawn freeze and per-character invulnerability windows.
module stomp_arbiter
  import stomp_arb_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int unsigned RESPAWN_FRAMES   = DEF_RESPAWN_FRAMES,
  parameter int unsigned INVULN_FRAMES    = DEF_INVULN_FRAMES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  input  logic             start_req,
  input  logic             c1_contact,
  input  logic             c2_contact,
  input  logic             game_over,
  output logic             start_game,
  output logic             hit_c1,
  output logic             hit_c2,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] countdown,
  output logic             c1_invuln,
  output logic             c2_invuln,
  output logic             freeze
);

  arb_phase_t phase_q, phase_d;
  logic prio_q, prio_d;  // 0: character1 wins the next tie
  logic start_q, c1_q, c2_q;
  logic start_game_q, start_game_d;
  logic hit_c1_q, hit_c1_d;
  logic hit_c2_q, hit_c2_d;

  logic             main_load, inv1_load, inv2_load;
  logic [CNT_W-1:0] main_val, inv_val;
  logic [CNT_W-1:0] main_cnt, inv1_cnt, inv2_cnt;
  logic             main_one, main_zero, inv1_one, inv1_zero, inv2_one, inv2_zero;
  logic             main_en, inv_en;
  logic             start_rise, c1_valid, c2_valid;
  logic             unused_flags;

  assign start_rise = start_req & ~start_q;
  assign c1_valid   = c1_contact & ~c1_q & inv2_zero;
  assign c2_valid   = c2_contact & ~c2_q & inv1_zero;
  assign main_en    = (phase_q == COUNTDOWN) || (phase_q == RESPAWN);
  assign inv_en     = (phase_q != IDLE);

  always_comb begin
    phase_d      = phase_q;
    prio_d       = prio_q;
    start_game_d = 1'b0;
    hit_c1_d     = 1'b0;
    hit_c2_d     = 1'b0;
    main_load    = 1'b0;
    main_val     = '0;
    inv1_load    = 1'b0;
    inv2_load    = 1'b0;
    inv_val      = CNT_W'(INVULN_FRAMES);

    case (phase_q)
      IDLE: begin
        if (start_rise) begin
          phase_d   = COUNTDOWN;
          main_load = 1'b1;
          main_val  = CNT_W'(COUNTDOWN_FRAMES);
        end
      end
      COUNTDOWN: begin
        if (main_one) begin
          phase_d      = ACTIVE;
          start_game_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (game_over) begin
          phase_d = HALT;
        end else if (c1_valid && c2_valid) begin
          hit_c1_d = ~prio_q;
          hit_c2_d = prio_q;
          prio_d   = ~prio_q;
        end else begin
          hit_c1_d = c1_valid;
          hit_c2_d = c2_valid;
        end
      end
      RESPAWN: begin
        if (game_over) begin
          phase_d = HALT;
        end else if (main_one) begin
          phase_d = ACTIVE;
        end
      end
      HALT:    phase_d = HALT;
      default: phase_d = IDLE;
    endcase

    if (hit_c1_d || hit_c2_d) begin
      phase_d   = RESPAWN;
      main_load = 1'b1;
      main_val  = CNT_W'(RESPAWN_FRAMES);
      inv2_load = hit_c1_d;
      inv1_load = hit_c2_d;
    end

    // Entering or sitting in HALT wipes every window.
    if (phase_d == HALT) begin
      main_load = 1'b1;
      main_val  = '0;
      inv1_load = 1'b1;
      inv2_load = 1'b1;
      inv_val   = '0;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q      <= IDLE;
      prio_q       <= 1'b0;
      start_q      <= 1'b0;
      c1_q         <= 1'b0;
      c2_q         <= 1'b0;
      start_game_q <= 1'b0;
      hit_c1_q     <= 1'b0;
      hit_c2_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      prio_q       <= prio_d;
      start_q      <= start_req;
      c1_q         <= c1_contact;
      c2_q         <= c2_contact;
      start_game_q <= start_game_d;
      hit_c1_q     <= hit_c1_d;
      hit_c2_q     <= hit_c2_d;
    end
  end

  // Countdown and respawn never overlap, so they share one counter.
  frame_down_counter #(.CNT_W(CNT_W)) u_main_cnt (
    .clk(frame_clk), .rst_n(Reset_n), .load(main_load), .load_val(main_val),
    .en(main_en), .count(main_cnt), .is_one(main_one), .is_zero(main_zero)
  );

  frame_down_counter #(.CNT_W(CNT_W)) u_inv1_cnt (
    .clk(frame_clk), .rst_n(Reset_n), .load(inv1_load), .load_val(inv_val),
    .en(inv_en), .count(inv1_cnt), .is_one(inv1_one), .is_zero(inv1_zero)
  );

  frame_down_counter #(.CNT_W(CNT_W)) u_inv2_cnt (
    .clk(frame_clk), .rst_n(Reset_n), .load(inv2_load), .load_val(inv_val),
    .en(inv_en), .count(inv2_cnt), .is_one(inv2_one), .is_zero(inv2_zero)
  );

  assign unused_flags = ^{main_zero, inv1_one, inv2_one, inv1_cnt, inv2_cnt};

  assign start_game = start_game_q;
  assign hit_c1     = hit_c1_q;
  assign hit_c2     = hit_c2_q;
  assign phase      = phase_q;
  assign countdown  = (phase_q == COUNTDOWN) ? main_cnt : '0;
  assign c1_invuln  = ~inv1_zero;
  assign c2_invuln  = ~inv2_zero;
  assign freeze     = (phase_q != ACTIVE);

endmodule
